// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: 24-hour clock with RUN / SET_HR / SET_MIN modes and a blink phase for the field being set
module clock_mode_ctrl #(
    parameter int INIT_HOUR = 0,
    parameter int INIT_MIN  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [1:0] mode,
    output logic       blink
);
    typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} state_t;

    state_t     mode_q;
    logic [4:0] hour_q, hour_d;
    logic [5:0] min_q, min_d, sec_q, sec_d;
    logic       blink_q;

    // >= rather than == so a bad preload still wraps back into range
    always_comb begin
        hour_d = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
        min_d  = (min_q  >= 6'd59) ? 6'd0 : min_q + 6'd1;
        sec_d  = (sec_q  >= 6'd59) ? 6'd0 : sec_q + 6'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hour_q  <= 5'(INIT_HOUR);
            min_q   <= 6'(INIT_MIN);
            sec_q   <= 6'd0;
            mode_q  <= RUN;
            blink_q <= 1'b1;
        end else begin
            case (mode_q)
                RUN: begin
                    blink_q <= 1'b1;
                    if (tick) begin
                        sec_q <= sec_d;
                        if (sec_q >= 6'd59) begin
                            min_q <= min_d;
                            if (min_q >= 6'd59) hour_q <= hour_d;
                        end
                    end
                    if (btn_mode) mode_q <= SET_HR;
                end
                SET_HR: begin
                    if (btn_mode) begin
                        mode_q  <= SET_MIN;
                        blink_q <= 1'b1;
                    end else if (btn_inc) begin
                        hour_q  <= hour_d;
                        blink_q <= 1'b1;
                    end else if (tick) begin
                        blink_q <= ~blink_q;
                    end
                end
                SET_MIN: begin
                    if (btn_mode) begin
                        mode_q  <= RUN;
                        sec_q   <= 6'd0;
                        blink_q <= 1'b1;
                    end else if (btn_inc) begin
                        min_q   <= min_d;
                        blink_q <= 1'b1;
                    end else if (tick) begin
                        blink_q <= ~blink_q;
                    end
                end
                default: begin
                    mode_q  <= RUN;
                    blink_q <= 1'b1;
                end
            endcase
        end
    end

    assign hour  = hour_q;
    assign min   = min_q;
    assign sec   = sec_q;
    assign mode  = mode_q;
    assign blink = blink_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: vector table, directed corner sequences and random stimulus against a seconds-of-day model
module tb_clock_mode_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0, tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [4:0] hour;
    logic [5:0] min, sec;
    logic [1:0] mode;
    logic       blink;

    clock_mode_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hour(hour), .min(min), .sec(sec), .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    int m_t = 0, m_mode = 0, m_blink = 1;

    typedef struct {
        bit t, bm, bi, r;
        int h, m, s, md, bl;
    } vec_t;
    vec_t vt[19];

    task automatic chk(input string nm, input int h, input int m, input int s, input int md, input int bl);
        n_cmp++;
        if ({hour, min, sec, mode, blink} !== {5'(h), 6'(m), 6'(s), 2'(md), 1'(bl)}) begin
            n_fail++;
            $display("FAIL %s: got %0d:%0d:%0d mode %0d blink %0d, want %0d:%0d:%0d mode %0d blink %0d",
                     nm, hour, min, sec, mode, blink, h, m, s, md, bl);
        end
    endtask

    // time kept as seconds of day; fields derived by division
    task automatic model_upd(input bit t, input bit bm, input bit bi, input bit r);
        int h, mi;
        if (r) begin
            m_t = 0; m_mode = 0; m_blink = 1;
        end else if (m_mode == 0) begin
            if (t) m_t = (m_t + 1) % 86400;
            if (bm) m_mode = 1;
            m_blink = 1;
        end else if (bm) begin
            if (m_mode == 2) m_t = m_t - m_t % 60;
            m_mode = (m_mode + 1) % 3;
            m_blink = 1;
        end else if (bi) begin
            h  = m_t / 3600;
            mi = (m_t / 60) % 60;
            if (m_mode == 1) m_t = m_t + (((h + 1) % 24) - h) * 3600;
            else             m_t = m_t + (((mi + 1) % 60) - mi) * 60;
            m_blink = 1;
        end else if (t) begin
            m_blink = 1 - m_blink;
        end
    endtask

    task automatic step(input bit t, input bit bm, input bit bi, input bit r);
        tick = t; btn_mode = bm; btn_inc = bi; rst = r;
        model_upd(t, bm, bi, r);
        @(posedge clk);
        #1;
        chk("model", m_t / 3600, (m_t / 60) % 60, m_t % 60, m_mode, m_blink);
        tick = 0; btn_mode = 0; btn_inc = 0; rst = 0;
    endtask

    initial begin
        vt = '{
            '{0,0,0,1, 0,0,0,0,1},
            '{1,0,0,0, 0,0,1,0,1},
            '{1,0,0,0, 0,0,2,0,1},
            '{1,0,0,0, 0,0,3,0,1},
            '{0,0,1,0, 0,0,3,0,1},
            '{0,1,0,0, 0,0,3,1,1},
            '{1,0,0,0, 0,0,3,1,0},
            '{1,0,0,0, 0,0,3,1,1},
            '{1,0,0,0, 0,0,3,1,0},
            '{1,0,1,0, 1,0,3,1,1},
            '{0,1,1,0, 1,0,3,2,1},
            '{0,0,1,0, 1,1,3,2,1},
            '{1,0,0,0, 1,1,3,2,0},
            '{0,1,0,0, 1,1,0,0,1},
            '{1,1,0,0, 1,1,1,1,1},
            '{0,0,1,0, 2,1,1,1,1},
            '{0,1,0,0, 2,1,1,2,1},
            '{0,0,1,1, 0,0,0,0,1},
            '{1,0,0,0, 0,0,1,0,1}
        };
        step(0, 0, 0, 1);
        for (int i = 0; i < 19; i++) begin
            step(vt[i].t, vt[i].bm, vt[i].bi, vt[i].r);
            chk($sformatf("vec%0d", i), vt[i].h, vt[i].m, vt[i].s, vt[i].md, vt[i].bl);
        end

        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        repeat (25) step(0, 0, 1, 0);
        chk("hr25", 1, 0, 0, 1, 1);
        step(0, 1, 0, 0);
        repeat (61) step(0, 0, 1, 0);
        chk("min61", 1, 1, 0, 2, 1);
        step(0, 1, 0, 0);
        chk("exit_set", 1, 1, 0, 0, 1);

        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        repeat (23) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        repeat (59) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        repeat (59) step(1, 0, 0, 0);
        chk("pre_wrap", 23, 59, 59, 0, 1);
        step(1, 0, 0, 0);
        chk("day_wrap", 0, 0, 0, 0, 1);

        step(0, 1, 0, 0);
        chk("blink_entry", 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0);
            chk($sformatf("blink_t%0d", i), 0, 0, 0, 1, (i % 2 == 0) ? 0 : 1);
        end

        repeat (5) step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        chk("bm_bi_hr5", 5, 0, 0, 2, 1);
        step(0, 1, 0, 0);
        repeat (10) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("tick_bm_sec10", 5, 0, 11, 1, 1);

        step(0, 1, 0, 0);
        repeat (7) step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        chk("rst_in_setmin", 0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 25, $urandom_range(0, 999) < 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
